// File: rtl/lcg_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcg_stim_pkg
// Purpose  : Shared types and constants for the LCG stimulus/response engine:
//            stimulus mode and FSM state enums, LCG default constants, MISR
//            feedback taps and the 32-bit chunk-count helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lcg_stim_pkg;

   // Stimulus pattern selected at start. RSVD is treated as LCG.
   typedef enum logic [1:0] {
      MODE_LCG   = 2'd0,
      MODE_WALK1 = 2'd1,
      MODE_ALT   = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_PRESENT = 2'd2
   } state_e;

   localparam logic [31:0] c_lcg_mul = 32'h41C6_4E6D;
   localparam logic [31:0] c_lcg_inc = 32'h0000_3039;

   // Feedback taps of the signature register: bits 31, 21, 1 and 0.
   localparam logic [31:0] c_misr_taps = 32'h8020_0003;

   // Number of 32-bit slices needed to cover a vector of the given width.
   function automatic int nchunk(input int width);
      return (width + 31) / 32;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcg_stim_misr.sv
`default_nettype none
// ============================================================================
// Module   : lcg_stim_misr
// Purpose  : 32-bit multiple-input signature register. Folds an OUT_W-bit
//            response sample into 32 bits (XOR of all 32-bit slices, top
//            slice zero-padded) and merges it into a shifting LFSR state.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            clear      - synchronous clear of the signature (wins over a
//                         coincident sample)
//            resp_valid - sample strobe
//            resp_data  - OUT_W-bit response sample
//            signature  - current 32-bit signature
// Revision : 1.0 - initial release
// ============================================================================
module lcg_stim_misr
   import lcg_stim_pkg::*;
#(
   parameter int OUT_W = 330
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             resp_valid,
   input  logic [OUT_W-1:0] resp_data,
   output logic [31:0]      signature
);

   localparam int c_nslice = nchunk(OUT_W);
   localparam int c_pad_w  = c_nslice * 32;

   logic [c_pad_w-1:0] w_padded;
   logic [31:0]        w_fold;
   logic [31:0]        sig_q;
   logic [31:0]        sig_d;

   generate
      if (c_pad_w > OUT_W) begin : g_pad
         assign w_padded = {{(c_pad_w - OUT_W){1'b0}}, resp_data};
      end else begin : g_nopad
         assign w_padded = resp_data;
      end
   endgenerate

   always_comb begin
      w_fold = '0;
      for (int s = 0; s < c_nslice; s++) begin
         w_fold = w_fold ^ w_padded[s*32 +: 32];
      end
   end

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (resp_valid) begin
         sig_d = {sig_q[30:0], ^(sig_q & c_misr_taps)} ^ w_fold;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;

endmodule
`default_nettype wire

// File: rtl/lcg_stim_engine.sv
`default_nettype none
// ============================================================================
// Module   : lcg_stim_engine
// Purpose  : Stimulus/response engine for fuzz harnesses. Emits cycles+1
//            IN_W-bit stimulus words over valid/ready (LCG, walking-one or
//            alternating patterns) and compresses the response stream into a
//            32-bit MISR signature.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start               - launch pulse (ignored while busy)
//            seed, cycles, mode  - run configuration, sampled on start
//            stim_valid/ready    - stimulus handshake
//            stim_data           - IN_W-bit stimulus word
//            resp_valid/data     - OUT_W-bit response sample strobe/data
//            busy                - run in progress
//            done                - pulse on the cycle the last word is taken
//            word_cnt            - words accepted in the current run
//            signature           - MISR state
// Revision : 1.0 - initial release
// ============================================================================
module lcg_stim_engine
   import lcg_stim_pkg::*;
#(
   parameter int          IN_W    = 260,
   parameter int          OUT_W   = 330,
   parameter logic [31:0] LCG_MUL = c_lcg_mul,
   parameter logic [31:0] LCG_INC = c_lcg_inc
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      seed,
   input  logic [31:0]      cycles,
   input  logic [1:0]       mode,
   output logic             stim_valid,
   input  logic             stim_ready,
   output logic [IN_W-1:0]  stim_data,
   input  logic             resp_valid,
   input  logic [OUT_W-1:0] resp_data,
   output logic             busy,
   output logic             done,
   output logic [31:0]      word_cnt,
   output logic [31:0]      signature
);

   localparam int c_nchunk  = nchunk(IN_W);
   localparam int c_chunk_w = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
   localparam int c_pos_w   = (IN_W > 1) ? $clog2(IN_W) : 1;

   localparam logic [c_chunk_w-1:0] c_last_chunk = c_chunk_w'(c_nchunk - 1);
   localparam logic [c_pos_w-1:0]   c_last_pos   = c_pos_w'(IN_W - 1);

   state_e               state_q,    state_d;
   mode_e                mode_q,     mode_d;
   logic [31:0]          rng_q,      rng_d;
   logic [31:0]          cycles_q,   cycles_d;
   logic [31:0]          word_cnt_q, word_cnt_d;
   logic [c_chunk_w-1:0] chunk_q,    chunk_d;
   logic [c_pos_w-1:0]   walk_pos_q, walk_pos_d;
   logic [IN_W-1:0]      stim_q,     stim_d;

   logic [31:0]     w_rng_next;
   logic [IN_W-1:0] w_lcg_word;
   logic [IN_W-1:0] w_walk_word;
   logic [IN_W-1:0] w_alt_word;
   logic            w_start_ok;
   logic            w_accept;
   logic            w_last;

   assign w_rng_next = rng_q * LCG_MUL + LCG_INC;
   assign w_start_ok = start && (state_q == ST_IDLE);
   assign w_accept   = (state_q == ST_PRESENT) && stim_ready;
   assign w_last     = (word_cnt_q == cycles_q);

   // Current word with the active chunk replaced by the next LCG value; the
   // top chunk keeps only as many low bits as remain of IN_W.
   generate
      for (genvar k = 0; k < c_nchunk; k++) begin : g_chunk
         localparam int c_lo = 32 * k;
         localparam int c_w  = ((IN_W - c_lo) >= 32) ? 32 : (IN_W - c_lo);
         assign w_lcg_word[c_lo +: c_w] = (chunk_q == c_chunk_w'(k))
                                          ? w_rng_next[c_w-1:0]
                                          : stim_q[c_lo +: c_w];
      end
   endgenerate

   // walk_pos tracks word_cnt mod IN_W incrementally, avoiding a divider.
   generate
      for (genvar b = 0; b < IN_W; b++) begin : g_walk
         assign w_walk_word[b] = (walk_pos_q == c_pos_w'(b));
      end
   endgenerate

   assign w_alt_word = {IN_W{word_cnt_q[0]}};

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      rng_d      = rng_q;
      cycles_d   = cycles_q;
      word_cnt_d = word_cnt_q;
      chunk_d    = chunk_q;
      walk_pos_d = walk_pos_q;
      stim_d     = stim_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rng_d      = seed;
               cycles_d   = cycles;
               mode_d     = mode_e'(mode);
               word_cnt_d = '0;
               chunk_d    = '0;
               walk_pos_d = '0;
               state_d    = ST_FILL;
            end
         end

         ST_FILL: begin
            case (mode_q)
               MODE_WALK1: begin
                  stim_d  = w_walk_word;
                  state_d = ST_PRESENT;
               end
               MODE_ALT: begin
                  stim_d  = w_alt_word;
                  state_d = ST_PRESENT;
               end
               default: begin
                  rng_d  = w_rng_next;
                  stim_d = w_lcg_word;
                  if (chunk_q == c_last_chunk) begin
                     chunk_d = '0;
                     state_d = ST_PRESENT;
                  end else begin
                     chunk_d = chunk_q + c_chunk_w'(1);
                  end
               end
            endcase
         end

         ST_PRESENT: begin
            if (stim_ready) begin
               // word_cnt wraps naturally when cycles is all-ones.
               word_cnt_d = word_cnt_q + 32'd1;
               walk_pos_d = (walk_pos_q == c_last_pos) ? '0
                                                       : walk_pos_q + c_pos_w'(1);
               chunk_d    = '0;
               state_d    = w_last ? ST_IDLE : ST_FILL;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_LCG;
         rng_q      <= '0;
         cycles_q   <= '0;
         word_cnt_q <= '0;
         chunk_q    <= '0;
         walk_pos_q <= '0;
         stim_q     <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         rng_q      <= rng_d;
         cycles_q   <= cycles_d;
         word_cnt_q <= word_cnt_d;
         chunk_q    <= chunk_d;
         walk_pos_q <= walk_pos_d;
         stim_q     <= stim_d;
      end
   end

   lcg_stim_misr #(
      .OUT_W (OUT_W)
   ) u_misr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (w_start_ok),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .signature  (signature)
   );

   assign stim_valid = (state_q == ST_PRESENT);
   assign stim_data  = stim_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = w_accept && w_last;
   assign word_cnt   = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lcg_stim_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcg_stim_engine
// Purpose  : Self-checking bench for lcg_stim_engine. Instance A uses
//            IN_W=40/OUT_W=64 (LCG, backpressure, reset, MISR); instance B
//            uses IN_W=8/OUT_W=64 (walking-one, alternating, reserved mode).
//            Expected words are queued when a run is launched and compared
//            when the DUT hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcg_stim_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        a_start, a_stim_valid, a_stim_ready, a_resp_valid, a_busy, a_done;
   logic [31:0] a_seed, a_cycles, a_word_cnt, a_signature;
   logic [1:0]  a_mode;
   logic [39:0] a_stim_data;
   logic [63:0] a_resp_data;

   logic        b_start, b_stim_valid, b_stim_ready, b_resp_valid, b_busy, b_done;
   logic [31:0] b_seed, b_cycles, b_word_cnt, b_signature;
   logic [1:0]  b_mode;
   logic [7:0]  b_stim_data;
   logic [63:0] b_resp_data;

   lcg_stim_engine #(.IN_W(40), .OUT_W(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .seed(a_seed), .cycles(a_cycles),
      .mode(a_mode), .stim_valid(a_stim_valid), .stim_ready(a_stim_ready),
      .stim_data(a_stim_data), .resp_valid(a_resp_valid), .resp_data(a_resp_data),
      .busy(a_busy), .done(a_done), .word_cnt(a_word_cnt), .signature(a_signature)
   );

   lcg_stim_engine #(.IN_W(8), .OUT_W(64)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .seed(b_seed), .cycles(b_cycles),
      .mode(b_mode), .stim_valid(b_stim_valid), .stim_ready(b_stim_ready),
      .stim_data(b_stim_data), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
      .busy(b_busy), .done(b_done), .word_cnt(b_word_cnt), .signature(b_signature)
   );

   typedef struct packed {
      logic [39:0] data;
      logic        last;
      logic [31:0] idx;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lcg(input logic [31:0] x);
      return x * 32'h41C64E6D + 32'h00003039;
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [63:0] d);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ (d[31:0] ^ d[63:32]);
   endfunction

   // Queue n LCG words for instance A (two LCG steps per 40-bit word).
   task automatic push_lcg_a(input int n, input logic [31:0] seed);
      logic [31:0] r;
      exp_t e;
      r = seed;
      for (int i = 0; i < n; i++) begin
         r = lcg(r);
         e.data[31:0] = r;
         r = lcg(r);
         e.data[39:32] = r[7:0];
         e.last = (i == n - 1);
         e.idx  = i;
         qa.push_back(e);
      end
   endtask

   task automatic push_b(input logic [7:0] d, input logic last, input int idx);
      exp_t e;
      e.data = {32'd0, d};
      e.last = last;
      e.idx  = idx;
      qb.push_back(e);
   endtask

   task automatic start_a(input logic [31:0] s, input logic [31:0] c, input logic [1:0] m);
      @(posedge clk); #1;
      a_seed = s; a_cycles = c; a_mode = m; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
   endtask

   task automatic start_b(input logic [31:0] s, input logic [31:0] c, input logic [1:0] m);
      @(posedge clk); #1;
      b_seed = s; b_cycles = c; b_mode = m; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
   endtask

   task automatic wait_a_idle(input string tag, input int bound);
      int n = 0;
      while ((a_busy || qa.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(a_busy || qa.size() != 0), 64'd0);
   endtask

   task automatic wait_b_idle(input string tag, input int bound);
      int n = 0;
      while ((b_busy || qb.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(b_busy || qb.size() != 0), 64'd0);
   endtask

   task automatic wait_a_valid(input string tag, input int bound);
      int n = 0;
      while (!a_stim_valid && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(a_stim_valid), 64'd1);
   endtask

   // Scoreboards: a word is handed over when valid and ready are both high
   // at the following rising edge.
   always @(negedge clk) begin
      if (rst_n && a_stim_valid && a_stim_ready) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL a_unexpected_word observed=%0h expected=none", a_stim_data);
         end else begin
            ea = qa.pop_front();
            check("a_data", 64'(a_stim_data), 64'(ea.data));
            check("a_done", 64'(a_done), 64'(ea.last));
            check("a_word_cnt", 64'(a_word_cnt), 64'(ea.idx));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_stim_valid && b_stim_ready) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL b_unexpected_word observed=%0h expected=none", b_stim_data);
         end else begin
            eb = qb.pop_front();
            check("b_data", 64'(b_stim_data), 64'(eb.data[7:0]));
            check("b_done", 64'(b_done), 64'(eb.last));
            check("b_word_cnt", 64'(b_word_cnt), 64'(eb.idx));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [39:0] held;
      logic [31:0] held_cnt;
      logic [31:0] sig_m;
      logic [63:0] d;

      rst_n = 1'b0;
      a_start = 1'b0; a_seed = '0; a_cycles = '0; a_mode = '0;
      a_stim_ready = 1'b0; a_resp_valid = 1'b0; a_resp_data = '0;
      b_start = 1'b0; b_seed = '0; b_cycles = '0; b_mode = '0;
      b_stim_ready = 1'b0; b_resp_valid = 1'b0; b_resp_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_valid", 64'(a_stim_valid), 64'd0);
      check("rst_a_busy", 64'(a_busy), 64'd0);
      check("rst_a_done", 64'(a_done), 64'd0);
      check("rst_a_word_cnt", 64'(a_word_cnt), 64'd0);
      check("rst_a_signature", 64'(a_signature), 64'd0);
      check("rst_a_data", 64'(a_stim_data), 64'd0);
      check("rst_b_busy", 64'(b_busy), 64'd0);
      check("rst_b_data", 64'(b_stim_data), 64'd0);
      rst_n = 1'b1;

      // Single LCG word: valid rises two cycles after FILL entry
      a_stim_ready = 1'b1;
      ea.data = 40'h7E_0000_3039; ea.last = 1'b1; ea.idx = 32'd0;
      qa.push_back(ea);
      start_a(32'd0, 32'd0, 2'd0);
      @(negedge clk);
      check("t1_valid_fill0", 64'(a_stim_valid), 64'd0);
      check("t1_busy", 64'(a_busy), 64'd1);
      @(negedge clk);
      check("t1_valid_fill1", 64'(a_stim_valid), 64'd0);
      @(negedge clk);
      check("t1_valid_present", 64'(a_stim_valid), 64'd1);
      check("t1_done_on_accept", 64'(a_done), 64'd1);
      wait_a_idle("t1_timeout", 20);
      check("t1_word_cnt_end", 64'(a_word_cnt), 64'd1);

      // Backpressure: three words, five stalled cycles on the first
      a_stim_ready = 1'b0;
      push_lcg_a(3, 32'd0);
      start_a(32'd0, 32'd2, 2'd0);
      wait_a_valid("t2_first_valid", 20);
      held = a_stim_data;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_stall_valid", 64'(a_stim_valid), 64'd1);
         check("t2_stall_data", 64'(a_stim_data), 64'(held));
      end
      @(posedge clk); #1;
      a_stim_ready = 1'b1;
      wait_a_idle("t2_timeout", 50);
      check("t2_word_cnt_end", 64'(a_word_cnt), 64'd3);

      // start while busy is ignored
      a_stim_ready = 1'b0;
      push_lcg_a(2, 32'd5);
      start_a(32'd5, 32'd1, 2'd0);
      wait_a_valid("t3_first_valid", 20);
      held = a_stim_data;
      held_cnt = a_word_cnt;
      start_a(32'hDEAD_BEEF, 32'd7, 2'd1);
      @(negedge clk);
      check("t3_busy_start_data", 64'(a_stim_data), 64'(held));
      check("t3_busy_start_cnt", 64'(a_word_cnt), 64'(held_cnt));
      a_stim_ready = 1'b1;
      wait_a_idle("t3_timeout", 50);
      check("t3_word_cnt_end", 64'(a_word_cnt), 64'd2);

      // Reset during FILL, then reproduce the first word
      start_a(32'h0000_1234, 32'd3, 2'd0);
      #1 rst_n = 1'b0;
      #1;
      check("t4_rst_busy", 64'(a_busy), 64'd0);
      check("t4_rst_valid", 64'(a_stim_valid), 64'd0);
      check("t4_rst_data", 64'(a_stim_data), 64'd0);
      check("t4_rst_word_cnt", 64'(a_word_cnt), 64'd0);
      check("t4_rst_done", 64'(a_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_lcg_a(1, 32'h0000_1234);
      start_a(32'h0000_1234, 32'd0, 2'd0);
      wait_a_idle("t4_timeout", 20);

      // MISR in IDLE
      check("t5_sig_initial", 64'(a_signature), 64'd0);
      d = 64'h00000001_00000003;
      @(posedge clk); #1;
      a_resp_valid = 1'b1; a_resp_data = d;
      @(posedge clk); #1;
      a_resp_valid = 1'b0;
      check("t5_sig_first", 64'(a_signature), 64'h2);
      sig_m = misr(32'd0, d);
      @(posedge clk); #1;
      a_resp_valid = 1'b1;
      @(posedge clk); #1;
      a_resp_valid = 1'b0;
      sig_m = misr(sig_m, d);
      check("t5_sig_second", 64'(a_signature), 64'(sig_m));

      // start and resp_valid together: clear wins
      push_lcg_a(1, 32'd9);
      @(posedge clk); #1;
      a_seed = 32'd9; a_cycles = 32'd0; a_mode = 2'd0;
      a_start = 1'b1; a_resp_valid = 1'b1; a_resp_data = 64'hFFFF_0000_1234_5678;
      @(posedge clk); #1;
      a_start = 1'b0; a_resp_valid = 1'b0;
      check("t5_sig_clear_wins", 64'(a_signature), 64'd0);
      sig_m = 32'd0;
      for (int i = 0; i < 3; i++) begin
         d = {$urandom, $urandom};
         a_resp_data = d; a_resp_valid = 1'b1;
         @(posedge clk); #1;
         sig_m = misr(sig_m, d);
      end
      a_resp_valid = 1'b0;
      check("t5_sig_during_run", 64'(a_signature), 64'(sig_m));
      wait_a_idle("t5_timeout", 20);

      // Walking-one on IN_W=8, ten words
      b_stim_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push_b(8'd1 << (i % 8), (i == 9), i);
      end
      start_b(32'd0, 32'd9, 2'd1);
      wait_b_idle("t6_timeout", 100);
      check("t6_word_cnt_end", 64'(b_word_cnt), 64'd10);

      // Alternating all-0/all-1
      push_b(8'h00, 1'b0, 0);
      push_b(8'hFF, 1'b0, 1);
      push_b(8'h00, 1'b0, 2);
      push_b(8'hFF, 1'b1, 3);
      start_b(32'd0, 32'd3, 2'd2);
      wait_b_idle("t7_timeout", 100);

      // Reserved mode behaves as LCG (one chunk per word at IN_W=8)
      sig_m = lcg(32'h77);
      push_b(sig_m[7:0], 1'b0, 0);
      sig_m = lcg(sig_m);
      push_b(sig_m[7:0], 1'b1, 1);
      start_b(32'h77, 32'd1, 2'd3);
      wait_b_idle("t8_timeout", 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
